// File: rtl/regfile_queue_ctrl_if.sv
// Handshake and regfile-port bundle for regfile_queue_ctrl.
// The slave modport is the controller's view; master is the surrounding
// producer/consumer/regfile view.
interface regfile_queue_ctrl_if #(
  parameter int unsigned p_nbits    = 4,
  parameter int unsigned p_nentries = 4
);
  localparam int unsigned c_addr_nbits = $clog2(p_nentries);
  localparam int unsigned c_cnt_nbits  = c_addr_nbits + 1;

  // Enqueue side
  logic                    enq_val;
  logic                    enq_rdy;
  logic [p_nbits-1:0]      enq_msg;

  // Dequeue side
  logic                    deq_val;
  logic                    deq_rdy;
  logic [p_nbits-1:0]      deq_msg;

  // Regfile ports
  logic                    rf_wen;
  logic [c_addr_nbits-1:0] rf_waddr;
  logic [p_nbits-1:0]      rf_wdata;
  logic [c_addr_nbits-1:0] rf_raddr;
  logic [p_nbits-1:0]      rf_rdata;

  // Occupancy
  logic [c_cnt_nbits-1:0]  count;

  modport slave (
    input  enq_val,
    input  enq_msg,
    input  deq_rdy,
    input  rf_rdata,
    output enq_rdy,
    output deq_val,
    output deq_msg,
    output rf_wen,
    output rf_waddr,
    output rf_wdata,
    output rf_raddr,
    output count
  );

  modport master (
    output enq_val,
    output enq_msg,
    output deq_rdy,
    output rf_rdata,
    input  enq_rdy,
    input  deq_val,
    input  deq_msg,
    input  rf_wen,
    input  rf_waddr,
    input  rf_wdata,
    input  rf_raddr,
    input  count
  );
endinterface

// File: rtl/regfile_queue_ctrl.sv
// FIFO control for a 1r1w flat regfile: owns the enqueue/dequeue pointers
// and the occupancy count; the regfile beside it owns all storage.
module regfile_queue_ctrl #(
  parameter int unsigned p_nbits    = 4,
  parameter int unsigned p_nentries = 4
) (
  input logic                  clk,
  input logic                  rst,
  regfile_queue_ctrl_if.slave  q
);
  localparam int unsigned c_addr_nbits = $clog2(p_nentries);
  localparam int unsigned c_cnt_nbits  = c_addr_nbits + 1;
  localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_nentries);

  logic [c_addr_nbits-1:0] enq_ptr_q, enq_ptr_d;
  logic [c_addr_nbits-1:0] deq_ptr_q, deq_ptr_d;
  logic [c_cnt_nbits-1:0]  count_q, count_d;

  logic enq_rdy;
  logic deq_val;
  logic enq_go;
  logic deq_go;

  // Handshake status from registered state only; rst masks enq_rdy so it
  // drops the instant reset asserts (count_q clears async, covering deq_val).
  always_comb begin
    enq_rdy = ~rst & (count_q != c_full);
    deq_val = ~rst & (count_q != '0);
    enq_go  = q.enq_val & enq_rdy;
    deq_go  = deq_val & q.deq_rdy;
  end

  // Next-state: pointers wrap by natural modulo of their width.
  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (enq_go) enq_ptr_d = enq_ptr_q + 1'b1;
    if (deq_go) deq_ptr_d = deq_ptr_q + 1'b1;
    unique case ({enq_go, deq_go})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; async reset discards queue contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  assign q.enq_rdy  = enq_rdy;
  assign q.deq_val  = deq_val;
  assign q.deq_msg  = q.rf_rdata;
  assign q.rf_wen   = enq_go;
  assign q.rf_waddr = enq_ptr_q;
  assign q.rf_wdata = q.enq_msg;
  assign q.rf_raddr = deq_ptr_q;
  assign q.count    = count_q;

endmodule

// File: tb/tb_regfile_queue_ctrl.sv
// Bench for regfile_queue_ctrl: a behavioural regfile plus a reference
// queue model, scenario tasks with inline comparisons.
module tb_regfile_queue_ctrl;
  localparam int unsigned NB = 4;
  localparam int unsigned NE = 4;

  logic clk = 1'b0;
  logic rst;

  regfile_queue_ctrl_if #(.p_nbits(NB), .p_nentries(NE)) bus ();

  regfile_queue_ctrl #(.p_nbits(NB), .p_nentries(NE)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 1r1w regfile
  logic [NB-1:0] mem [NE];
  always @(posedge clk) if (bus.rf_wen) mem[bus.rf_waddr] <= bus.rf_wdata;
  assign bus.rf_rdata = mem[bus.rf_raddr];

  int total = 0;
  int bad   = 0;

  logic [NB-1:0] model_q [$];
  int unsigned   enq_total;

  // Advance one clock, updating the reference queue from the handshake rules.
  task automatic tick();
    bit            eg, dg;
    logic [NB-1:0] m;
    eg = bus.enq_val && (model_q.size() < NE);
    dg = bus.deq_rdy && (model_q.size() > 0);
    m  = bus.enq_msg;
    @(posedge clk);
    if (dg) void'(model_q.pop_front());
    if (eg) begin
      model_q.push_back(m);
      enq_total++;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.enq_val = 1'b0;
    bus.deq_rdy = 1'b0;
    model_q.delete();
    enq_total = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enq_val = 1'b0;
    bus.deq_rdy = 1'b0;
    bus.enq_msg = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL rst_hold_count got=%0d want=0", bus.count); end
    total++; if (bus.enq_rdy !== 1'b0) begin bad++; $display("FAIL rst_hold_enq_rdy got=%b want=0", bus.enq_rdy); end
    rst = 1'b0;
    #1;
    model_q.delete();
    enq_total = 0;
    bus.enq_val = 1'b1; bus.enq_msg = 4'h3; tick();
    bus.enq_msg = 4'h7; tick();
    bus.enq_val = 1'b0;
    total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL pre_rst_count got=%0d want=2", bus.count); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", bus.count); end
    total++; if (bus.deq_val !== 1'b0) begin bad++; $display("FAIL midrst_deq_val got=%b want=0", bus.deq_val); end
    total++; if (bus.enq_rdy !== 1'b0) begin bad++; $display("FAIL midrst_enq_rdy got=%b want=0", bus.enq_rdy); end
    model_q.delete();
    enq_total = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (bus.enq_rdy !== 1'b1) begin bad++; $display("FAIL postrst_enq_rdy got=%b want=1", bus.enq_rdy); end
    total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL postrst_rf_wen got=%b want=0", bus.rf_wen); end
    total++; if (bus.deq_val !== 1'b0) begin bad++; $display("FAIL postrst_deq_val got=%b want=0", bus.deq_val); end
  endtask

  task automatic test_single();
    bus.enq_val = 1'b1; bus.enq_msg = 4'ha; bus.deq_rdy = 1'b0;
    #1;
    total++; if (bus.rf_wen !== 1'b1) begin bad++; $display("FAIL single_rf_wen got=%b want=1", bus.rf_wen); end
    total++; if (bus.rf_wdata !== 4'ha) begin bad++; $display("FAIL single_rf_wdata got=%h want=a", bus.rf_wdata); end
    total++; if (bus.deq_val !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%b want=0", bus.deq_val); end
    tick();
    bus.enq_val = 1'b0;
    #1;
    total++; if (bus.deq_val !== 1'b1) begin bad++; $display("FAIL single_deq_val got=%b want=1", bus.deq_val); end
    total++; if (bus.deq_msg !== 4'ha) begin bad++; $display("FAIL single_deq_msg got=%h want=a", bus.deq_msg); end
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", bus.count); end
    bus.deq_rdy = 1'b1;
    tick();
    bus.deq_rdy = 1'b0;
    #1;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL single_drain_count got=%0d want=0", bus.count); end
    total++; if (bus.deq_val !== 1'b0) begin bad++; $display("FAIL single_drain_val got=%b want=0", bus.deq_val); end
  endtask

  task automatic test_fill_drain();
    logic [NB-1:0] v;
    for (int i = 1; i <= 4; i++) begin
      bus.enq_val = 1'b1; bus.enq_msg = NB'(i);
      tick();
    end
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", bus.count); end
    total++; if (bus.enq_rdy !== 1'b0) begin bad++; $display("FAIL fill_enq_rdy got=%b want=0", bus.enq_rdy); end
    bus.enq_msg = 4'h5;
    #1;
    total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL full_rf_wen got=%b want=0", bus.rf_wen); end
    tick();
    bus.enq_val = 1'b0;
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_hold_count got=%0d want=4", bus.count); end
    bus.deq_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      v = NB'(i);
      #1;
      total++; if (bus.deq_val !== 1'b1) begin bad++; $display("FAIL drain_val[%0d] got=%b want=1", i, bus.deq_val); end
      total++; if (bus.deq_msg !== v) begin bad++; $display("FAIL drain_msg[%0d] got=%h want=%h", i, bus.deq_msg, v); end
      tick();
    end
    bus.deq_rdy = 1'b0;
    #1;
    total++; if (bus.deq_val !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", bus.deq_val); end
  endtask

  task automatic test_wrap();
    int unsigned   exp_addr [6] = '{0, 1, 2, 3, 0, 1};
    logic [NB-1:0] v;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      v = NB'(i);
      bus.enq_val = 1'b1; bus.enq_msg = v; bus.deq_rdy = 1'b0;
      #1;
      total++; if (bus.rf_waddr !== 2'(exp_addr[i])) begin bad++; $display("FAIL wrap_waddr[%0d] got=%0d want=%0d", i, bus.rf_waddr, exp_addr[i]); end
      tick();
      bus.enq_val = 1'b0; bus.deq_rdy = 1'b1;
      #1;
      total++; if (bus.rf_raddr !== 2'(exp_addr[i])) begin bad++; $display("FAIL wrap_raddr[%0d] got=%0d want=%0d", i, bus.rf_raddr, exp_addr[i]); end
      total++; if (bus.deq_msg !== v) begin bad++; $display("FAIL wrap_msg[%0d] got=%h want=%h", i, bus.deq_msg, v); end
      tick();
    end
    bus.deq_rdy = 1'b0;
  endtask

  task automatic test_full_simul();
    logic [NB-1:0] head;
    for (int i = 0; i < 4; i++) begin
      bus.enq_val = 1'b1; bus.enq_msg = NB'($urandom);
      tick();
    end
    bus.enq_msg = 4'hf; bus.deq_rdy = 1'b1;
    #1;
    total++; if (bus.enq_rdy !== 1'b0) begin bad++; $display("FAIL simul_enq_rdy got=%b want=0", bus.enq_rdy); end
    total++; if (bus.rf_wen !== 1'b0) begin bad++; $display("FAIL simul_rf_wen got=%b want=0", bus.rf_wen); end
    tick();
    bus.enq_val = 1'b0; bus.deq_rdy = 1'b0;
    #1;
    head = model_q[0];
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL simul_count got=%0d want=3", bus.count); end
    total++; if (bus.deq_msg !== head) begin bad++; $display("FAIL simul_head got=%h want=%h", bus.deq_msg, head); end
  endtask

  task automatic test_random();
    int unsigned sz;
    for (int c = 0; c < 200; c++) begin
      bus.enq_val = 1'($urandom);
      bus.deq_rdy = 1'($urandom);
      bus.enq_msg = NB'($urandom);
      #1;
      sz = model_q.size();
      total++; if (bus.count !== 3'(sz)) begin bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, bus.count, sz); end
      total++; if (bus.enq_rdy !== (sz < NE)) begin bad++; $display("FAIL rnd_enq_rdy c=%0d got=%b want=%b", c, bus.enq_rdy, sz < NE); end
      total++; if (bus.deq_val !== (sz > 0)) begin bad++; $display("FAIL rnd_deq_val c=%0d got=%b want=%b", c, bus.deq_val, sz > 0); end
      if (sz > 0) begin
        total++; if (bus.deq_msg !== model_q[0]) begin bad++; $display("FAIL rnd_deq_msg c=%0d got=%h want=%h", c, bus.deq_msg, model_q[0]); end
      end
      tick();
    end
    bus.enq_val = 1'b0; bus.deq_rdy = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NE; i++) mem[i] = '0;
    enq_total = 0;
    test_reset();
    test_single();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
